// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, skid buffer and redirect discard
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        req_q, req_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;

    logic [31:0] pc_plus4;
    logic        slot_free;

    assign pc_plus4  = pc_q + 32'd4;
    assign slot_free = !id_valid_q || !stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        discard_d     = discard_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;

        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            state_d    = S_REQ;
            discard_d  = 1'b0;
            // A request already accepted by memory must have its response swallowed
            if ((state_q == S_REQ && req_q && imem_gnt) ||
                (state_q == S_WAIT && !imem_rvalid)) begin
                state_d   = S_WAIT;
                discard_d = 1'b1;
            end
        end else begin
            if (!stall) begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end
            case (state_q)
                S_REQ: begin
                    if (req_q && imem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            pc_d = pc_plus4;
                            if (slot_free) begin
                                id_valid_d    = 1'b1;
                                id_instr_d    = imem_rdata;
                                id_pc_d       = pc_q;
                                id_pc_plus4_d = pc_plus4;
                            end else begin
                                skid_instr_d = imem_rdata;
                                skid_pc_d    = pc_q;
                                state_d      = S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = skid_instr_q;
                        id_pc_d       = skid_pc_q;
                        id_pc_plus4_d = skid_pc_q + 32'd4;
                        state_d       = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            discard_q     <= 1'b0;
            req_q         <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= 32'd0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            discard_q     <= discard_d;
            req_q         <= req_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;

    logic        a_req, a_valid, b_req, b_valid;
    logic [31:0] a_addr, a_instr, a_pc, a_p4, b_addr, b_instr, b_pc, b_p4;
    logic        sel;
    logic        m_req, m_valid;
    logic [31:0] m_addr, m_instr, m_pc, m_p4;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .id_valid(a_valid), .id_instr(a_instr), .id_pc(a_pc), .id_pc_plus4(a_p4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .id_valid(b_valid), .id_instr(b_instr), .id_pc(b_pc), .id_pc_plus4(b_p4)
    );

    assign m_req   = sel ? b_req   : a_req;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_instr = sel ? b_instr : a_instr;
    assign m_pc    = sel ? b_pc    : a_pc;
    assign m_p4    = sel ? b_p4    : a_p4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [63:0] sb_q[$];
    logic [31:0] exp_pc;
    logic        pend, pend_kill;
    logic [31:0] pend_addr;
    int          cnt, lat;
    logic        redir, redir_on_gnt;
    logic [31:0] redir_pc;
    logic        stall_v, stall_on_valid;
    logic        override_en;
    logic [31:0] override_word;
    logic        prev_held;
    logic [31:0] prev_instr, prev_pc, prev_p4;
    logic        dead_seen;
    int          new_cnt, gnt_cnt;
    int          new_cyc[16];
    logic [31:0] new_pc[16], new_p4[16];
    logic [31:0] gnt_seen_addr;
    logic [31:0] held_pc;
    int          g0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic reset_model(input logic [31:0] rpc);
        sb_q.delete();
        exp_pc    = rpc;
        if (pend) pend_kill = 1'b1;
        prev_held = 1'b0;
        stall_v   = 1'b0;
        new_cnt   = 0;
    endtask

    task automatic tick();
        logic [63:0] e;
        logic        fresh, resp_now, resp_kill;
        @(negedge clk);
        cyc++;
        fresh = 1'b0;
        if (m_valid) begin
            if (prev_held) begin
                check_eq("hold_instr", m_instr, prev_instr);
                check_eq("hold_pc", m_pc, prev_pc);
                check_eq("hold_pc_plus4", m_p4, prev_p4);
            end else begin
                fresh = 1'b1;
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("id_pc", m_pc, e[63:32]);
                    check_eq("id_instr", m_instr, e[31:0]);
                    check_eq("id_pc_plus4", m_p4, e[63:32] + 32'd4);
                end
                if (new_cnt < 16) begin
                    new_cyc[new_cnt] = cyc;
                    new_pc[new_cnt]  = m_pc;
                    new_p4[new_cnt]  = m_p4;
                end
                new_cnt++;
            end
            if (m_instr == 32'h0000_DEAD) dead_seen = 1'b1;
        end else begin
            check_eq("idle_nop", m_instr, NOP);
        end
        prev_instr = m_instr;
        prev_pc    = m_pc;
        prev_p4    = m_p4;

        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        resp_now    = 1'b0;
        resp_kill   = 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = override_en ? override_word : mem_word(pend_addr);
                resp_now    = 1'b1;
                resp_kill   = pend_kill;
                pend        = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (m_req && !pend) begin
            imem_gnt = 1'b1;
            check_eq("req_addr", m_addr, exp_pc);
            pend          = 1'b1;
            pend_addr     = m_addr;
            pend_kill     = 1'b0;
            cnt           = lat;
            gnt_seen_addr = m_addr;
            gnt_cnt++;
        end
        if (redir_on_gnt && imem_gnt) begin
            redir        = 1'b1;
            redir_on_gnt = 1'b0;
        end
        if (resp_now && !resp_kill && !redir) begin
            sb_q.push_back({exp_pc, mem_word(exp_pc)});
            exp_pc = exp_pc + 32'd4;
        end
        if (redir) begin
            if (pend) pend_kill = 1'b1;
            sb_q.delete();
            exp_pc = redir_pc & ~32'd3;
        end
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        redir          = 1'b0;
        if (fresh && stall_on_valid) begin
            stall_v        = 1'b1;
            stall_on_valid = 1'b0;
        end
        stall     = stall_v;
        prev_held = m_valid && stall;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; sel = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
        pend = 1'b0; pend_kill = 1'b0; pend_addr = 32'd0; cnt = 0; lat = 0;
        redir = 1'b0; redir_on_gnt = 1'b0; redir_pc = 32'd0;
        stall_v = 1'b0; stall_on_valid = 1'b0;
        override_en = 1'b0; override_word = 32'd0;
        prev_held = 1'b0; prev_instr = 32'd0; prev_pc = 32'd0; prev_p4 = 32'd0;
        dead_seen = 1'b0; new_cnt = 0; gnt_cnt = 0; gnt_seen_addr = 32'd0;
        held_pc = 32'd0; g0 = 0;
        reset_model(32'h0000_0000);

        // reset values and release behaviour
        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(m_req), 32'd0);
        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_instr", m_instr, NOP);
        check_eq("rst_pc", m_pc, 32'd0);
        check_eq("rst_pc_plus4", m_p4, 32'd0);
        rst_n = 1'b1;
        #1 check_eq("req_release_cycle", 32'(m_req), 32'd0);
        tick();
        check_eq("req_after_release", 32'(m_req), 32'd1);

        // 1: zero-wait stream, one instruction every second cycle
        for (int i = 0; i < 40 && new_cnt < 3; i++) tick();
        check_eq("t1_count", 32'(new_cnt >= 3), 32'd1);
        check_eq("t1_gap0", 32'(new_cyc[1] - new_cyc[0]), 32'd2);
        check_eq("t1_gap1", 32'(new_cyc[2] - new_cyc[1]), 32'd2);
        check_eq("t1_pc0", new_pc[0], 32'd0);
        check_eq("t1_pc1", new_pc[1], 32'd4);
        check_eq("t1_pc2", new_pc[2], 32'd8);

        // 2: stall with a response in flight goes through the skid
        new_cnt = 0;
        stall_on_valid = 1'b1;
        for (int i = 0; i < 20 && new_cnt < 1; i++) tick();
        check_eq("t2_first", 32'(new_cnt), 32'd1);
        held_pc = new_pc[0];
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2_req_low", 32'(m_req), 32'd0);
            check_eq("t2_held_pc", m_pc, held_pc);
        end
        stall_v = 1'b0;
        for (int i = 0; i < 10 && new_cnt < 2; i++) tick();
        check_eq("t2_second", 32'(new_cnt), 32'd2);
        check_eq("t2_skid_pc", new_pc[1], held_pc + 32'd4);

        // 3: redirect while waiting; the late response is discarded
        lat = 2;
        dead_seen = 1'b0;
        tick();
        for (int i = 0; i < 20 && !imem_gnt; i++) tick();
        override_en = 1'b1;
        override_word = 32'h0000_DEAD;
        redir = 1'b1;
        redir_pc = 32'h0000_0100;
        g0 = gnt_cnt;
        tick();
        for (int i = 0; i < 20 && gnt_cnt == g0; i++) tick();
        override_en = 1'b0;
        check_eq("t3_regnt", 32'(gnt_cnt > g0), 32'd1);
        check_eq("t3_addr", gnt_seen_addr, 32'h0000_0100);
        new_cnt = 0;
        for (int i = 0; i < 20 && new_cnt < 1; i++) tick();
        check_eq("t3_first_pc", new_pc[0], 32'h0000_0100);
        check_eq("t3_dead_seen", 32'(dead_seen), 32'd0);

        // 4: misaligned redirect coinciding with a grant
        lat = 0;
        redir_on_gnt = 1'b1;
        redir_pc = 32'h0000_0103;
        g0 = gnt_cnt;
        for (int i = 0; i < 30 && gnt_cnt < g0 + 2; i++) tick();
        check_eq("t4_addr", gnt_seen_addr, 32'h0000_0100);
        new_cnt = 0;
        for (int i = 0; i < 20 && new_cnt < 1; i++) tick();
        check_eq("t4_first_pc", new_pc[0], 32'h0000_0100);

        // 5: PC wrap from the top of the address space
        rst_n = 1'b0;
        sel = 1'b1;
        reset_model(32'hFFFF_FFFC);
        tick();
        rst2_n = 1'b1;
        #1 check_eq("t5_req_release", 32'(m_req), 32'd0);
        for (int i = 0; i < 30 && new_cnt < 2; i++) tick();
        check_eq("t5_pc0", new_pc[0], 32'hFFFF_FFFC);
        check_eq("t5_p4_0", new_p4[0], 32'd0);
        check_eq("t5_pc1", new_pc[1], 32'd0);

        // 6: asynchronous reset in WAIT, late response afterwards
        rst2_n = 1'b0;
        sel = 1'b0;
        reset_model(32'h0000_0000);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20 && new_cnt < 2; i++) tick();
        lat = 2;
        tick();
        for (int i = 0; i < 20 && !imem_gnt; i++) tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_req", 32'(m_req), 32'd0);
        check_eq("t6_valid", 32'(m_valid), 32'd0);
        check_eq("t6_instr", m_instr, NOP);
        check_eq("t6_pc", m_pc, 32'd0);
        check_eq("t6_pc_plus4", m_p4, 32'd0);
        reset_model(32'h0000_0000);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40 && new_cnt < 2; i++) tick();
        check_eq("t6_count", 32'(new_cnt >= 2), 32'd1);
        check_eq("t6_pc0", new_pc[0], 32'd0);
        check_eq("t6_pc1", new_pc[1], 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
